// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of the single-cycle core.
// Issues one outstanding word request at a time to a variable-latency
// instruction memory, buffers responses in a DEPTH-entry FIFO and presents
// the FIFO head to the core with a valid/ready handshake. A branch redirect
// flushes the FIFO. A response that is still in flight at the time of the
// redirect is drained and thrown away.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   branch_en/target       one-cycle redirect request and new word address
//   imem_req/addr          registered memory request and word address
//   imem_ack/data          memory response strobe and instruction word
//   instr_valid/instr/     FIFO head: valid flag, instruction word, and
//   instr_addr             word address
//   instr_ready            core accepts the head this cycle
module fetch_unit #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          branch_en,
  input  logic [AW-1:0] branch_target,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_data,
  output logic          instr_valid,
  output logic [31:0]   instr,
  output logic [AW-1:0] instr_addr,
  input  logic          instr_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          req_q, req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0]   mem_data_q [DEPTH];
  logic [AW-1:0] mem_addr_q [DEPTH];

  logic          push;
  logic          pop;
  logic          flush;
  logic [CW-1:0] cnt_after;

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = (cnt_q != '0);
  assign instr       = mem_data_q[rd_ptr_q];
  assign instr_addr  = mem_addr_q[rd_ptr_q];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_d     = req_q;
    addr_d    = addr_q;
    push      = 1'b0;
    flush     = 1'b0;
    pop       = instr_valid & instr_ready;
    // Occupancy if this cycle's response is pushed alongside any pop.
    cnt_after = cnt_q + CW'(1) - CW'(pop);

    unique case (state_q)
      IDLE: begin
        if (branch_en) begin
          pc_d  = branch_target;
          flush = 1'b1;
        end else if (cnt_q < DEPTH_C) begin
          // Free slot now: the response can always be stored.
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (branch_en) begin
          flush = 1'b1;
          pc_d  = branch_target;
          if (imem_ack) begin
            req_d   = 1'b0;
            state_d = IDLE;
          end else begin
            // Request cannot be withdrawn; wait for it and discard it.
            state_d = DRAIN;
          end
        end else if (imem_ack) begin
          push = 1'b1;
          pc_d = addr_q + AW'(1);
          if (cnt_after < DEPTH_C) begin
            addr_d = addr_q + AW'(1);
          end else begin
            req_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (branch_en) pc_d = branch_target;
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      cnt_d    = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Payload storage carries no reset; it is only read while instr_valid=1.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= imem_data;
      mem_addr_q[wr_ptr_q] <= addr_q;
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the single-cycle core.
- Replaces the combinational ROM read with a request/acknowledge instruction-memory interface that has variable latency.
- Prefetches sequential word addresses into a small FIFO and presents them to the core with a valid/ready handshake.
- Handles branch redirects: flushes the FIFO and discards any in-flight response.

Parameters:
- DEPTH, 4, number of prefetch FIFO entries (power of two, at least 2).
- AW, 32, address width. The PC counts 32-bit words and increments by 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- branch_en  in  1  redirect request from the branch unit, valid for one cycle.
- branch_target  in  AW  new fetch address when branch_en=1.
- imem_req  out  1  instruction-memory request, registered.
- imem_addr  out  AW  request word address, registered, stable while imem_req=1.
- imem_ack  in  1  memory response strobe, sampled only while imem_req=1.
- imem_data  in  32  instruction word, valid when imem_ack=1.
- instr_valid  out  1  FIFO head valid.
- instr  out  32  FIFO head instruction.
- instr_addr  out  AW  word address of the FIFO head.
- instr_ready  in  1  core accepts the head; pop when instr_valid & instr_ready.

Behaviour:

Reset (asynchronous):
- fetch_pc=0, FIFO empty (count=0, rd_ptr=wr_ptr=0), state=IDLE.
- imem_req=0, imem_addr=0, instr_valid=0.
- instr and instr_addr drive the stored head entry; their value is don't-care while instr_valid=0.

State IDLE:
- If branch_en: fetch_pc<=branch_target; stay in IDLE.
- Else if count<DEPTH: imem_req<=1, imem_addr<=fetch_pc; go to WAIT.
- Else stay in IDLE.

State WAIT (imem_req=1):
- imem_ack=0, branch_en=0: hold req and addr unchanged.
- imem_ack=1, branch_en=0:
  - Push {imem_data, imem_addr}; fetch_pc<=imem_addr+1.
  - If count after this cycle's push and pop is <DEPTH: stay in WAIT with imem_addr<=imem_addr+1 (back-to-back fetch).
  - Else: imem_req<=0; go to IDLE.
- imem_ack=1, branch_en=1: discard the response; flush; fetch_pc<=branch_target; imem_req<=0; go to IDLE.
- imem_ack=0, branch_en=1: flush; fetch_pc<=branch_target; go to DRAIN. imem_req stays 1, because a request is never withdrawn.

State DRAIN (imem_req=1):
- On imem_ack: discard the data; imem_req<=0; go to IDLE.
- branch_en in DRAIN: fetch_pc<=branch_target (the latest target wins); stay in DRAIN unless ack.
- The FIFO stays empty throughout.

FIFO rules:
- instr_valid = (count!=0).
- Push and pop in the same cycle: count unchanged, both pointers advance.
- No overflow is possible: a request is issued only when a slot is guaranteed, and only one request is outstanding.
- Pointers wrap modulo DEPTH.
- Flush sets count=0 and rd_ptr=wr_ptr. Flush overrides any pop or push in the same cycle.
- fetch_pc and imem_addr wrap modulo 2^AW.

Latency:
- First request is asserted at the first rising edge after reset deasserts.
- With immediate ack (ack=1 at the edge following req), the first instr_valid is high after edge 2, and throughput is 1 instruction/cycle.
- After a redirect from IDLE: target request at edge+1, valid at edge+2 at the earliest.

Test Plan:
- Reset release; memory acks every cycle with data=addr^32'hA5A5_0000; instr_ready=1 -> instr_addr sequence 0,1,2,3,4 on consecutive cycles from cycle 2; instr matches; imem_req never drops.
- instr_ready=0, memory always acks -> exactly 4 pushes (addr 0..3); imem_req drops after the 4th ack; instr_addr=0 held. Set ready=1 for one cycle -> the pop frees a slot; a new request for addr 4 appears the next cycle.
- Memory ack latency 3 cycles; branch_en=1, target=0x40 in the 2nd wait cycle of the request for addr 2 -> FIFO empty next cycle; state DRAIN; the addr-2 data is never presented; next request addr=0x40; first valid instr_addr=0x40.
- branch_en coincident with imem_ack for addr 5, target=0x10 -> addr-5 data discarded; instr_valid=0 next cycle; next imem_addr=0x10.
- Two branches in DRAIN (targets 0x20, then 0x30) before the ack arrives -> the post-drain request addr is 0x30.
- Assert reset asynchronously mid-WAIT with FIFO holding 2 entries -> imem_req and instr_valid drop immediately without a clock edge; after release, fetch restarts at addr 0.
